// File: rtl/sdram_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the SDRAM controller.
// master = arbiter view, slave = requester/controller view.
interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [1:0]        m0_wlen;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic [1:0]        m1_wlen;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_wlen;
    logic              mem_en_n;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  m0_req, m0_addr, m0_wdata, m0_wlen,
        output m0_ack, m0_rdata,
        input  m1_req, m1_addr, m1_wdata, m1_wlen,
        output m1_ack, m1_rdata,
        output mem_addr, mem_wdata, mem_wlen, mem_en_n,
        input  mem_ready, mem_rdata
    );

    modport slave (
        output m0_req, m0_addr, m0_wdata, m0_wlen,
        input  m0_ack, m0_rdata,
        output m1_req, m1_addr, m1_wdata, m1_wlen,
        input  m1_ack, m1_rdata,
        input  mem_addr, mem_wdata, mem_wlen, mem_en_n,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter in front of a single-transaction SDRAM controller, with watchdog abort.
// Define SDRAM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module sdram_port_arbiter #(
    parameter int ADDR_W  = 26,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    sdram_port_arbiter_if.master bus,
    output logic                 grant,
    output logic                 timeout_err
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;

    state_t            state, next_state;
    logic [WD_W-1:0]   wd;
    logic              wd_hit;
    logic              last_grant;
    logic              any_req;
    logic              pick;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        wlen_q;
    logic              en_n_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    assign any_req = bus.m0_req | bus.m1_req;
    assign wd_hit  = (wd == WD_W'(TIMEOUT - 1));

`ifdef SDRAM_ARB_RR_EN
    assign pick = (bus.m0_req & bus.m1_req) ? ~last_grant : bus.m1_req;
`else
    // Only consulted when some request is up, so with m0_req low m1_req is set and pick is 1.
    assign pick = ~bus.m0_req & (bus.m1_req | last_grant);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (any_req) next_state = ISSUE;
            ISSUE:     if (wd_hit) next_state = RESP;
                       else if (!bus.mem_ready) next_state = WAIT_DONE;
            WAIT_DONE: if (wd_hit || bus.mem_ready) next_state = RESP;
            RESP:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            wlen_q      <= '0;
            en_n_q      <= 1'b1;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            timeout_err <= 1'b0;
            wd          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        addr_q  <= pick ? bus.m1_addr  : bus.m0_addr;
                        wdata_q <= pick ? bus.m1_wdata : bus.m0_wdata;
                        wlen_q  <= pick ? bus.m1_wlen  : bus.m0_wlen;
                        grant   <= pick;
                        en_n_q  <= 1'b0;
                        wd      <= '0;
                    end
                end
                ISSUE, WAIT_DONE: begin
                    wd <= wd + 1'b1;
                    if (wd_hit) begin
                        en_n_q      <= 1'b1;
                        timeout_err <= 1'b1;
                        if (grant) rdata1_q <= '0;
                        else       rdata0_q <= '0;
                    end else if (state == ISSUE) begin
                        if (!bus.mem_ready) en_n_q <= 1'b1;
                    end else if (bus.mem_ready && wlen_q == 2'b00) begin
                        if (grant) rdata1_q <= bus.mem_rdata;
                        else       rdata0_q <= bus.mem_rdata;
                    end
                end
                RESP: last_grant <= grant;
                default: ;
            endcase
        end
    end

    // Ack is a pure decode of the single RESP cycle, so only the granted port can see it.
    assign bus.m0_ack    = (state == RESP) && !grant;
    assign bus.m1_ack    = (state == RESP) &&  grant;
    assign bus.m0_rdata  = rdata0_q;
    assign bus.m1_rdata  = rdata1_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wlen  = wlen_q;
    assign bus.mem_en_n  = en_n_q;
endmodule
